ram_arb: RTL and testbench

Two-port arbiter that shares the single 32-bit main-RAM port between the CPU path (gated by the gate array's RAM chip-enable) and a secondary DMA requester (the CD-sector / MMC transfer engine). It sits in `mach` between the CPU bus and the top-level `RAM_*` pins. It serialises transactions, registers all RAM-side controls, and guarantees the DMA port a bounded wait.

---
 rtl/ram_arb_pkg.sv | 26 ++
 rtl/ram_arb.sv | 139 +++++++++++++
 tb/tb_ram_arb.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the main-RAM arbiter: FSM state encoding,
// RAM bus widths and the registered RAM command bundle.
package ram_arb_pkg;

    localparam int RAM_AW = 21;
    localparam int RAM_DW = 32;
    localparam int RAM_BW = RAM_DW / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_XFER = 2'd1,
        DMA_XFER = 2'd2,
        CPU_DONE = 2'd3
    } ram_arb_state_t;

    // Everything latched into the RAM_* registers at grant time.
    typedef struct packed {
        logic [RAM_AW-1:0] a;
        logic [RAM_DW-1:0] di;
        logic              wen;
        logic [RAM_BW-1:0] ben;
    } ram_cmd_t;

    localparam ram_cmd_t RAM_CMD_RESET = '{a: '0, di: '0, wen: 1'b1, ben: '0};

endpackage

// File: rtl/ram_arb.sv
// Shares the single main-RAM port between the CPU and the DMA engine.
// CPU normally wins; after STARVE_MAX CPU grants with DMA pending, DMA wins.
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RES,
    input  logic              C_CEn,
    input  logic              C_BCYSTn,
    input  logic [RAM_AW-1:0] C_A,
    input  logic [RAM_DW-1:0] C_DI,
    input  logic              C_WEn,
    input  logic [RAM_BW-1:0] C_BEn,
    output logic [RAM_DW-1:0] C_DO,
    output logic              C_READYn,
    input  logic              D_REQ,
    input  logic [RAM_AW-1:0] D_A,
    input  logic [RAM_DW-1:0] D_DI,
    input  logic              D_WE,
    input  logic [RAM_BW-1:0] D_BEn,
    output logic [RAM_DW-1:0] D_DO,
    output logic              D_ACK,
    output logic              RAM_CEn,
    output logic [RAM_AW-1:0] RAM_A,
    output logic [RAM_DW-1:0] RAM_DI,
    output logic              RAM_WEn,
    output logic [RAM_BW-1:0] RAM_BEn,
    input  logic [RAM_DW-1:0] RAM_DO,
    input  logic              RAM_READYn
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    ram_arb_state_t    state_q, state_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    ram_cmd_t          ram_cmd_q, ram_cmd_d;
    logic              ram_cen_q, ram_cen_d;
    logic [RAM_DW-1:0] c_do_q, c_do_d;
    logic [RAM_DW-1:0] d_do_q, d_do_d;
    logic              c_readyn_q, c_readyn_d;
    logic              d_ack_q, d_ack_d;

    logic              cpu_req, dma_req, dma_wins;
    ram_cmd_t          cpu_cmd, dma_cmd;

    // A D_REQ still high in the D_ACK cycle belongs to the finished transfer.
    assign cpu_req  = ~C_CEn;
    assign dma_req  = D_REQ & ~d_ack_q;
    assign dma_wins = dma_req & (~cpu_req | (starve_cnt_q >= STARVE_LIM));

    assign cpu_cmd = '{a: C_A, di: C_DI, wen: C_WEn, ben: C_BEn};
    assign dma_cmd = '{a: D_A, di: D_DI, wen: ~D_WE, ben: D_BEn};

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        ram_cmd_d    = ram_cmd_q;
        ram_cen_d    = ram_cen_q;
        c_do_d       = c_do_q;
        d_do_d       = d_do_q;
        d_ack_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dma_wins) begin
                    state_d      = DMA_XFER;
                    ram_cmd_d    = dma_cmd;
                    ram_cen_d    = 1'b0;
                    starve_cnt_d = '0;
                end else if (cpu_req) begin
                    state_d   = CPU_XFER;
                    ram_cmd_d = cpu_cmd;
                    ram_cen_d = 1'b0;
                    if (D_REQ && starve_cnt_q < STARVE_LIM)
                        starve_cnt_d = starve_cnt_q + 8'd1;
                end
            end
            CPU_XFER: begin
                if (!RAM_READYn) begin
                    state_d   = CPU_DONE;
                    ram_cen_d = 1'b1;
                    c_do_d    = RAM_DO;
                end
            end
            DMA_XFER: begin
                if (!RAM_READYn) begin
                    state_d   = IDLE;
                    ram_cen_d = 1'b1;
                    d_do_d    = RAM_DO;
                    d_ack_d   = 1'b1;
                end
            end
            CPU_DONE: begin
                if (C_CEn || !C_BCYSTn)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        c_readyn_d = (state_d != CPU_DONE);
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (RES) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            ram_cmd_q    <= RAM_CMD_RESET;
            ram_cen_q    <= 1'b1;
            c_do_q       <= '0;
            d_do_q       <= '0;
            c_readyn_q   <= 1'b1;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ram_cmd_q    <= ram_cmd_d;
            ram_cen_q    <= ram_cen_d;
            c_do_q       <= c_do_d;
            d_do_q       <= d_do_d;
            c_readyn_q   <= c_readyn_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign C_DO     = c_do_q;
    assign C_READYn = c_readyn_q;
    assign D_DO     = d_do_q;
    assign D_ACK    = d_ack_q;
    assign RAM_CEn  = ram_cen_q;
    assign RAM_A    = ram_cmd_q.a;
    assign RAM_DI   = ram_cmd_q.di;
    assign RAM_WEn  = ram_cmd_q.wen;
    assign RAM_BEn  = ram_cmd_q.ben;

endmodule

// File: tb/tb_ram_arb.sv
// Self-checking bench for ram_arb: directed scenarios plus randomized traffic,
// every output compared each cycle against a transaction-level reference model.
module tb_ram_arb;

    localparam int SM = 3;

    logic        CLK = 1'b0;
    logic        RES;
    logic        C_CEn, C_BCYSTn, C_WEn;
    logic [20:0] C_A;
    logic [31:0] C_DI;
    logic [3:0]  C_BEn;
    logic [31:0] C_DO;
    logic        C_READYn;
    logic        D_REQ, D_WE;
    logic [20:0] D_A;
    logic [31:0] D_DI;
    logic [3:0]  D_BEn;
    logic [31:0] D_DO;
    logic        D_ACK;
    logic        RAM_CEn, RAM_WEn;
    logic [20:0] RAM_A;
    logic [31:0] RAM_DI;
    logic [3:0]  RAM_BEn;
    logic [31:0] RAM_DO;
    logic        RAM_READYn;

    ram_arb #(.STARVE_MAX(SM)) dut (
        .CLK(CLK), .RES(RES),
        .C_CEn(C_CEn), .C_BCYSTn(C_BCYSTn), .C_A(C_A), .C_DI(C_DI),
        .C_WEn(C_WEn), .C_BEn(C_BEn), .C_DO(C_DO), .C_READYn(C_READYn),
        .D_REQ(D_REQ), .D_A(D_A), .D_DI(D_DI), .D_WE(D_WE), .D_BEn(D_BEn),
        .D_DO(D_DO), .D_ACK(D_ACK),
        .RAM_CEn(RAM_CEn), .RAM_A(RAM_A), .RAM_DI(RAM_DI), .RAM_WEn(RAM_WEn),
        .RAM_BEn(RAM_BEn), .RAM_DO(RAM_DO), .RAM_READYn(RAM_READYn)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the RAM port and what each output should show.
    localparam int O_FREE = 0, O_CPU = 1, O_DMA = 2, O_HOLD = 3;
    int          m_own;
    int          m_starve;
    logic        e_ram_cen, e_ram_wen, e_c_readyn, e_d_ack;
    logic [20:0] e_ram_a;
    logic [31:0] e_ram_di, e_c_do, e_d_do;
    logic [3:0]  e_ram_ben;

    task automatic model_edge();
        logic ack_prev, cpu_w, dma_w;
        if (RES) begin
            m_own = O_FREE; m_starve = 0;
            e_ram_cen = 1'b1; e_ram_a = '0; e_ram_di = '0; e_ram_wen = 1'b1; e_ram_ben = '0;
            e_c_do = '0; e_d_do = '0; e_c_readyn = 1'b1; e_d_ack = 1'b0;
        end else begin
            ack_prev = e_d_ack;
            e_d_ack  = 1'b0;
            case (m_own)
                O_FREE: begin
                    cpu_w = !C_CEn;
                    dma_w = D_REQ && !ack_prev;
                    if (dma_w && (!cpu_w || m_starve == SM)) begin
                        e_ram_cen = 1'b0; e_ram_a = D_A; e_ram_di = D_DI;
                        e_ram_wen = !D_WE; e_ram_ben = D_BEn;
                        m_starve = 0; m_own = O_DMA;
                    end else if (cpu_w) begin
                        e_ram_cen = 1'b0; e_ram_a = C_A; e_ram_di = C_DI;
                        e_ram_wen = C_WEn; e_ram_ben = C_BEn;
                        if (D_REQ && m_starve < SM) m_starve++;
                        m_own = O_CPU;
                    end
                end
                O_CPU, O_DMA: begin
                    if (!RAM_READYn) begin
                        e_ram_cen = 1'b1;
                        if (m_own == O_CPU) begin
                            e_c_do = RAM_DO; m_own = O_HOLD;
                        end else begin
                            e_d_do = RAM_DO; e_d_ack = 1'b1; m_own = O_FREE;
                        end
                    end
                end
                default: if (C_CEn || !C_BCYSTn) m_own = O_FREE;
            endcase
            e_c_readyn = (m_own != O_HOLD);
        end
    endtask

    // RAM responder and transaction logging.
    int          force_lat = -1;
    int          lat_left  = 0;
    logic        last_cen  = 1'b1;
    logic        fixed_en  = 1'b0;
    logic [31:0] fixed_do  = '0;
    int          cyc       = 0;
    int          n_ack     = 0;
    logic [20:0] grant_a[$];
    int          grant_t[$];

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        cyc++;
        check("C_DO", C_DO, e_c_do);
        check("C_READYn", 32'(C_READYn), 32'(e_c_readyn));
        check("D_DO", D_DO, e_d_do);
        check("D_ACK", 32'(D_ACK), 32'(e_d_ack));
        check("RAM_CEn", 32'(RAM_CEn), 32'(e_ram_cen));
        check("RAM_A", 32'(RAM_A), 32'(e_ram_a));
        check("RAM_DI", RAM_DI, e_ram_di);
        check("RAM_WEn", 32'(RAM_WEn), 32'(e_ram_wen));
        check("RAM_BEn", 32'(RAM_BEn), 32'(e_ram_ben));
        if (D_ACK === 1'b1) n_ack++;
        if (RAM_CEn === 1'b0 && last_cen) begin
            grant_a.push_back(RAM_A);
            grant_t.push_back(cyc);
        end
        if (RAM_CEn === 1'b0) begin
            if (last_cen) lat_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            else if (lat_left > 0) lat_left--;
            RAM_READYn = (lat_left == 0) ? 1'b0 : 1'b1;
        end else begin
            RAM_READYn = 1'($urandom_range(0, 1));
        end
        RAM_DO   = fixed_en ? fixed_do : $urandom;
        last_cen = (RAM_CEn !== 1'b0);
    endtask

    task automatic do_reset();
        C_CEn = 1'b1; C_BCYSTn = 1'b1; D_REQ = 1'b0;
        RES = 1'b1;
        step();
        RES = 1'b0;
        grant_a.delete(); grant_t.delete();
        n_ack = 0;
    endtask

    localparam logic [20:0] CPU_ADDR = 21'h00AAA0;
    localparam logic [20:0] DMA_ADDR = 21'h155550;

    initial begin
        int dma_idx[$];
        int acks, t_rel;
        logic seen_low;

        RES = 1'b1; C_CEn = 1'b1; C_BCYSTn = 1'b1; C_A = '0; C_DI = '0; C_WEn = 1'b1; C_BEn = '0;
        D_REQ = 1'b0; D_A = '0; D_DI = '0; D_WE = 1'b0; D_BEn = '0;
        RAM_DO = '0; RAM_READYn = 1'b1;

        // Reset state
        do_reset();
        check("rst_cen", 32'(RAM_CEn), 32'd1);
        check("rst_wen", 32'(RAM_WEn), 32'd1);
        check("rst_creadyn", 32'(C_READYn), 32'd1);

        // CPU read, RAM ready one cycle after RAM_CEn
        C_CEn = 1'b0; C_A = 21'h000100; C_WEn = 1'b1; C_BEn = 4'h0;
        fixed_en = 1'b1; fixed_do = 32'hDEADBEEF; force_lat = 1;
        step();
        check("t1_cen_c1", 32'(RAM_CEn), 32'd0);
        check("t1_addr", 32'(RAM_A), 32'h100);
        check("t1_wen", 32'(RAM_WEn), 32'd1);
        step();
        check("t1_creadyn_c2", 32'(C_READYn), 32'd1);
        step();
        check("t1_creadyn_c3", 32'(C_READYn), 32'd0);
        check("t1_cdo", C_DO, 32'hDEADBEEF);
        check("t1_cen_c3", 32'(RAM_CEn), 32'd1);
        repeat (3) begin
            step();
            check("t1_hold", 32'(C_READYn), 32'd0);
        end
        C_CEn = 1'b1;
        step();
        check("t1_release", 32'(C_READYn), 32'd1);
        fixed_en = 1'b0;

        // DMA write alone
        do_reset();
        D_REQ = 1'b1; D_A = 21'h1FFFFC; D_DI = 32'h12345678; D_WE = 1'b1; D_BEn = 4'h0;
        force_lat = 0;
        step();
        check("t2_cen", 32'(RAM_CEn), 32'd0);
        check("t2_wen", 32'(RAM_WEn), 32'd0);
        check("t2_addr", 32'(RAM_A), 32'h1FFFFC);
        check("t2_di", RAM_DI, 32'h12345678);
        check("t2_ben", 32'(RAM_BEn), 32'd0);
        step();
        check("t2_ack", 32'(D_ACK), 32'd1);
        check("t2_cen_after", 32'(RAM_CEn), 32'd1);
        D_REQ = 1'b0;
        step();
        check("t2_ack_pulse", 32'(D_ACK), 32'd0);
        check("t2_cen_idle", 32'(RAM_CEn), 32'd1);
        repeat (3) step();
        check("t2_ack_count", 32'(n_ack), 32'd1);

        // Continuous CPU traffic with D_REQ held: starvation bound
        do_reset();
        force_lat = -1;
        C_CEn = 1'b0; C_A = CPU_ADDR; D_REQ = 1'b1; D_A = DMA_ADDR; D_WE = 1'b0;
        acks = 0;
        for (int i = 0; i < 300 && acks < 2; i++) begin
            step();
            if (D_ACK === 1'b1) acks++;
            C_BCYSTn = (C_READYn === 1'b0) ? 1'b0 : 1'b1;
        end
        check("t3_done", 32'(acks), 32'd2);
        dma_idx.delete();
        foreach (grant_a[i]) if (grant_a[i] == DMA_ADDR) dma_idx.push_back(i);
        check("t3_dma_grants", 32'(dma_idx.size()), 32'd2);
        if (dma_idx.size() >= 2) begin
            check("t3_first_dma", 32'(dma_idx[0]), 32'd3);
            check("t3_second_dma", 32'(dma_idx[1]), 32'd7);
        end
        C_BCYSTn = 1'b1;

        // Simultaneous requests with counter at 0
        do_reset();
        C_CEn = 1'b0; C_A = CPU_ADDR; D_REQ = 1'b1; D_A = DMA_ADDR;
        t_rel = -1; seen_low = 1'b0;
        for (int i = 0; i < 60 && n_ack == 0; i++) begin
            step();
            if (C_READYn === 1'b0) begin
                seen_low = 1'b1;
                C_CEn = 1'b1;
            end else if (seen_low && t_rel < 0) begin
                t_rel = cyc;
            end
            if (D_ACK === 1'b1) D_REQ = 1'b0;
        end
        check("t4_done", 32'(n_ack), 32'd1);
        check("t4_grants", 32'(grant_a.size()), 32'd2);
        if (grant_a.size() >= 2) begin
            check("t4_first_cpu", 32'(grant_a[0]), 32'(CPU_ADDR));
            check("t4_then_dma", 32'(grant_a[1]), 32'(DMA_ADDR));
            check("t4_dma_delay", 32'(grant_t[1] - t_rel), 32'd1);
        end

        // CPU_DONE exit by C_BCYSTn with C_CEn still low
        do_reset();
        force_lat = 0;
        C_CEn = 1'b0; C_A = CPU_ADDR;
        step();
        step();
        check("t5_done", 32'(C_READYn), 32'd0);
        C_BCYSTn = 1'b0;
        step();
        check("t5_ready_high", 32'(C_READYn), 32'd1);
        check("t5_cen_dead", 32'(RAM_CEn), 32'd1);
        C_BCYSTn = 1'b1;
        step();
        check("t5_regrant", 32'(RAM_CEn), 32'd0);
        check("t5_ready_still_high", 32'(C_READYn), 32'd1);
        C_CEn = 1'b1;
        repeat (4) step();

        // Reset during DMA_XFER abandons the transfer
        do_reset();
        force_lat = 3;
        D_REQ = 1'b1; D_A = DMA_ADDR;
        step();
        check("t6_granted", 32'(RAM_CEn), 32'd0);
        RES = 1'b1;
        step();
        RES = 1'b0; D_REQ = 1'b0;
        check("t6_cen", 32'(RAM_CEn), 32'd1);
        check("t6_ack", 32'(D_ACK), 32'd0);
        repeat (6) step();
        check("t6_no_ack", 32'(n_ack), 32'd0);
        C_CEn = 1'b0; C_A = CPU_ADDR;
        step();
        check("t6_idle_grant", 32'(RAM_CEn), 32'd0);
        check("t6_idle_addr", 32'(RAM_A), 32'(CPU_ADDR));

        // Randomized traffic
        force_lat = -1;
        for (int i = 0; i < 1500; i++) begin
            int bias;
            bias = (i / 250) % 3;
            RES      = ($urandom_range(0, 249) == 0);
            C_CEn    = ($urandom_range(0, 3) <= bias) ? 1'b0 : 1'b1;
            C_BCYSTn = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            C_A = 21'($urandom); C_DI = $urandom; C_WEn = 1'($urandom); C_BEn = 4'($urandom);
            if (D_REQ) begin
                if (D_ACK === 1'b1) begin
                    D_REQ = ($urandom_range(0, 2) == 0);
                    D_A = 21'($urandom); D_DI = $urandom; D_WE = 1'($urandom); D_BEn = 4'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                D_REQ = 1'b1;
                D_A = 21'($urandom); D_DI = $urandom; D_WE = 1'($urandom); D_BEn = 4'($urandom);
            end
            step();
        end
        RES = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
